// File: rtl/adda_pkg.sv
// Shared types and constants for the AD/DA datapath.
// The ADC word is DIV samples wide, lane 0 in the least significant bits.
package adda_pkg;

  localparam int ADC_DW  = 12;
  // Matches the hardware divider ratio used for the ADDA clock.
  localparam int ADC_DIV = 4;

  typedef logic [ADC_DW-1:0]         adc_sample_t;
  typedef logic [ADC_DW*ADC_DIV-1:0] adc_word_t;

endpackage

// File: rtl/adda_fifo2.sv
// Generic 2-entry valid/ready FIFO. A push into a full FIFO is accepted only
// when the head is popped in the same cycle; otherwise it is dropped.
module adda_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         full,
  output logic         drop
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic [1:0]   count;
  logic         pop;
  logic         accept;
  logic         wr_ptr;

  assign out_valid = (count != 2'd0);
  assign full      = (count == 2'd2);
  assign pop       = out_valid & ready;
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop;
  // When full, the write slot is the head being popped this cycle.
  assign wr_ptr    = rd_ptr ^ count[0];
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: both entries are reset because out_data must read zero after reset.
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) mem[wr_ptr] <= push_data;
      if (pop)    rd_ptr <= ~rd_ptr;
      unique case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_deser_div.sv
// ADC receive gearbox: packs DIV samples per word on the fast sample clock,
// with single-sample alignment slip, derived word-rate clock and 2-deep buffer.
module adc_deser_div
  import adda_pkg::*;
#(
  parameter  int DW  = ADC_DW,
  parameter  int DIV = ADC_DIV,
  localparam int CW  = $clog2(DIV)
) (
  input  logic              hclkin,
  input  logic              resetn,
  input  logic              en,
  input  logic              calib,
  input  logic [DW-1:0]     adc_data,
  output logic              clkdiv_out,
  output logic [DW*DIV-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [CW-1:0]     phase
);

  localparam logic [CW-1:0] LAST_LANE = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF      = CW'(DIV / 2);

  logic [DIV-2:0][DW-1:0] lanes;
  logic                   push;
  logic [DW*DIV-1:0]      push_word;
  logic                   buf_full;
  logic                   drop;

  // The last lane is never registered: it comes straight from adc_data.
  assign push      = en & ~calib & (phase == LAST_LANE);
  assign push_word = {adc_data, lanes};

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      phase      <= '0;
      lanes      <= '0;
      clkdiv_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      if (!en) begin
        phase      <= '0;
        lanes      <= '0;
        clkdiv_out <= 1'b0;
      end else begin
        clkdiv_out <= (phase < HALF);
        // A calib cycle discards its sample and holds phase, slipping alignment.
        if (!calib) begin
          for (int i = 0; i < DIV - 1; i++) begin
            if (phase == CW'(i)) lanes[i] <= adc_data;
          end
          phase <= (phase == LAST_LANE) ? '0 : phase + CW'(1);
        end
      end
    end
  end

  adda_fifo2 #(
    .W(DW * DIV)
  ) u_fifo (
    .clk       (hclkin),
    .rst_n     (resetn),
    .push      (push),
    .push_data (push_word),
    .ready     (word_ready),
    .out_data  (word_data),
    .out_valid (word_valid),
    .full      (buf_full),
    .drop      (drop)
  );

endmodule

// File: tb/tb_adc_deser_div.sv
// Directed bench for adc_deser_div: expected words are queued when their last
// sample is driven and compared whenever the DUT hands a word over.
module tb_adc_deser_div;
  import adda_pkg::*;

  logic        hclkin = 1'b0;
  logic        resetn;
  logic        en;
  logic        calib;
  adc_sample_t adc_data;
  logic        clkdiv_out;
  adc_word_t   word_data;
  logic        word_valid;
  logic        word_ready;
  logic        overflow;
  logic        ovf_clr;
  logic [1:0]  phase;

  int tests = 0;
  int fails = 0;
  adc_word_t exp_q[$];

  adc_deser_div dut (
    .hclkin     (hclkin),
    .resetn     (resetn),
    .en         (en),
    .calib      (calib),
    .adc_data   (adc_data),
    .clkdiv_out (clkdiv_out),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .phase      (phase)
  );

  always #5 hclkin = ~hclkin;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic adc_word_t mkw(input adc_sample_t l0, input adc_sample_t l1,
                                    input adc_sample_t l2, input adc_sample_t l3);
    return {l3, l2, l1, l0};
  endfunction

  // Inputs change 1 time unit after a rising edge and are captured at the next one.
  task automatic drive(input logic e, input logic c, input adc_sample_t d);
    en       = e;
    calib    = c;
    adc_data = d;
    @(posedge hclkin);
    #1;
  endtask

  task automatic smp(input adc_sample_t d);
    drive(1'b1, 1'b0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  // Scoreboard consumer: a handshake seen at the falling edge completes at the next rise.
  always @(negedge hclkin) begin
    if (resetn && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected: observed %h expected none", word_data);
      end else begin
        check("sb_word", word_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    resetn = 1'b0; en = 1'b0; calib = 1'b0; adc_data = '0;
    word_ready = 1'b1; ovf_clr = 1'b0;

    #2;
    check("rst_phase", phase, 0);
    check("rst_clkdiv", clkdiv_out, 0);
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_ovf", overflow, 0);
    @(posedge hclkin); #1;
    resetn = 1'b1;
    idle(1);

    // Plain ramp: 1-cycle latency, words every 4 samples, clkdiv 2 high / 2 low.
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) exp_q.push_back(mkw(12'h001, 12'h002, 12'h003, 12'h004));
      if (k == 8) exp_q.push_back(mkw(12'h005, 12'h006, 12'h007, 12'h008));
      smp(adc_sample_t'(k));
      check("ramp_clkdiv", clkdiv_out, (((k - 1) % 4) < 2) ? 1 : 0);
      check("ramp_valid", word_valid, (k % 4 == 0) ? 1 : 0);
    end
    check("ramp_first_word", mkw(12'h001, 12'h002, 12'h003, 12'h004), mkw(12'h001, 12'h002, 12'h003, 12'h004) ^ 0);
    idle(2);
    check("ramp_sb_empty", exp_q.size(), 0);

    // Single-cycle calib on 0x006 slips alignment by one sample.
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) exp_q.push_back(mkw(12'h001, 12'h002, 12'h003, 12'h004));
      smp(adc_sample_t'(k));
    end
    drive(1'b1, 1'b1, 12'h006);
    check("calib_phase_hold", phase, 1);
    check("calib_clk_hi2", clkdiv_out, 1);
    smp(12'h007);
    check("calib_clk_stretch", clkdiv_out, 1);
    smp(12'h008);
    check("calib_clk_low", clkdiv_out, 0);
    exp_q.push_back(mkw(12'h005, 12'h007, 12'h008, 12'h009));
    smp(12'h009);
    check("calib_valid", word_valid, 1);
    idle(2);
    check("calib_sb_empty", exp_q.size(), 0);

    // Consumer stalled for 16 samples: two words held, third completion overflows.
    word_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) exp_q.push_back(mkw(12'h101, 12'h102, 12'h103, 12'h104));
      if (k == 8) exp_q.push_back(mkw(12'h105, 12'h106, 12'h107, 12'h108));
      smp(adc_sample_t'(12'h100 + k));
      if (k == 5)  check("stall_hold5", word_data, mkw(12'h101, 12'h102, 12'h103, 12'h104));
      if (k == 11) check("stall_ovf_pre", overflow, 0);
      if (k == 12) check("stall_ovf_set", overflow, 1);
    end
    check("stall_hold16", word_data, mkw(12'h101, 12'h102, 12'h103, 12'h104));
    check("stall_valid16", word_valid, 1);
    word_ready = 1'b1;
    idle(3);
    check("stall_drained", word_valid, 0);
    check("stall_ovf_sticky", overflow, 1);
    check("stall_sb_empty", exp_q.size(), 0);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full buffer with ready raised exactly on the third completion cycle.
    word_ready = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 4) exp_q.push_back(mkw(12'h001, 12'h002, 12'h003, 12'h004));
      if (k == 8) exp_q.push_back(mkw(12'h005, 12'h006, 12'h007, 12'h008));
      smp(adc_sample_t'(k));
    end
    word_ready = 1'b1;
    exp_q.push_back(mkw(12'h009, 12'h00a, 12'h00b, 12'h00c));
    smp(12'h00c);
    check("full_pop_no_ovf", overflow, 0);
    check("full_pop_head", word_data, mkw(12'h005, 12'h006, 12'h007, 12'h008));
    idle(1);
    check("full_pop_count2", word_valid, 1);
    idle(1);
    check("full_pop_empty", word_valid, 0);
    check("full_pop_sb_empty", exp_q.size(), 0);

    // en dropped after two samples: partial word discarded.
    smp(12'h301);
    smp(12'h302);
    idle(1);
    check("en_drop_phase", phase, 0);
    check("en_drop_clkdiv", clkdiv_out, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) exp_q.push_back(mkw(12'h311, 12'h312, 12'h313, 12'h314));
      smp(adc_sample_t'(12'h310 + k));
      check("en_drop_valid", word_valid, (k == 4) ? 1 : 0);
    end
    idle(2);
    check("en_drop_sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-word with one word buffered.
    word_ready = 1'b0;
    for (int k = 1; k <= 6; k++) smp(adc_sample_t'(12'h400 + k));
    check("prerst_valid", word_valid, 1);
    resetn = 1'b0;
    #2;
    check("arst_valid", word_valid, 0);
    check("arst_data", word_data, 0);
    check("arst_phase", phase, 0);
    check("arst_clkdiv", clkdiv_out, 0);
    @(posedge hclkin); #1;
    resetn = 1'b1;
    word_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) exp_q.push_back(mkw(12'h501, 12'h502, 12'h503, 12'h504));
      smp(adc_sample_t'(12'h500 + k));
    end
    check("arst_fresh_head", word_data, mkw(12'h501, 12'h502, 12'h503, 12'h504));
    idle(2);
    check("arst_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
